div_seq: RTL and testbench

Multi-cycle divider sequencer for the EX stage. It accepts a signed or unsigned division request and computes one quotient bit per cycle with restoring division. It returns quotient and remainder, and raises a stall request for as long as EX is waiting. The stall request feeds the `stop_all_req_from_ex` input of the pipeline stall controller, so the front stages and EX freeze until the result is ready.

---
 rtl/div_seq.sv | 138 +++++++++++++
 tb/tb_div_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Purpose : multi-cycle restoring divider for EX (signed DIV / unsigned DIVU), one quotient bit per cycle.
// Latency : ready rises DATA_W+1 edges after acceptance (1 edge for a zero divisor); result holds while start stays high.
// Backpr. : stop_req = start & ~annul & ~ready stalls the pipeline until the result is consumed.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, annul        request (held until ready) / cancel, annul wins over start
//   signed_div          1 = two's complement divide, 0 = unsigned
//   opdata1, opdata2    dividend / divisor, sampled only on acceptance
//   quotient, remainder registered result, valid while ready
//   ready               registered result-valid flag
//   stop_req            combinational stall request to the stall controller
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              annul,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              ready,
  output logic              stop_req
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int PR_W  = 2 * DATA_W + 1;

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_e;

  state_e              state_q;
  logic [PR_W-1:0]     pr_q;        // {remainder, dividend/quotient, guard}
  logic [DATA_W-1:0]   div_mag_q;
  logic                q_neg_q;
  logic                r_neg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   quotient_q;
  logic [DATA_W-1:0]   remainder_q;
  logic                ready_q;

  logic [DATA_W-1:0]   a_mag_d;
  logic [DATA_W-1:0]   b_mag_d;
  logic [DATA_W-1:0]   hi_d;
  logic [DATA_W:0]     diff_d;
  logic [PR_W-1:0]     pr_d;
  logic [DATA_W-1:0]   q_raw_d;
  logic [DATA_W-1:0]   r_raw_d;

  // Operand magnitudes: only negate when dividing signed and the MSB is set.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  assign a_mag_d = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign b_mag_d = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

  // One restoring step. The dividend starts one bit up (guard bit at LSB),
  // so after DATA_W steps the quotient sits in the low bits and the
  // remainder in the top DATA_W bits.
  assign hi_d    = pr_q[2*DATA_W-1:DATA_W];
  assign diff_d  = {1'b0, hi_d} - {1'b0, div_mag_q};
  assign pr_d    = diff_d[DATA_W] ? {pr_q[PR_W-2:0], 1'b0}
                                  : {diff_d[DATA_W-1:0], pr_q[DATA_W-1:0], 1'b1};
  assign q_raw_d = pr_q[DATA_W-1:0];
  assign r_raw_d = pr_q[PR_W-1:DATA_W+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FREE;
      pr_q        <= '0;
      div_mag_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          if (start && !annul) begin
            if (opdata2 == '0) begin
              state_q <= BY_ZERO;
            end else begin
              state_q   <= ON;
              pr_q      <= {{DATA_W{1'b0}}, a_mag_d, 1'b0};
              div_mag_q <= b_mag_d;
              q_neg_q   <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
              r_neg_q   <= signed_div && opdata1[DATA_W-1];
              cnt_q     <= '0;
            end
          end
        end
        BY_ZERO: begin
          if (annul) begin
            state_q <= FREE;
          end else begin
            state_q     <= END;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b1;
          end
        end
        ON: begin
          if (annul) begin
            state_q <= FREE;
          end else if (cnt_q == CNT_W'(DATA_W)) begin
            // All bits produced: apply sign fix (truncate toward zero,
            // remainder follows the dividend's sign).
            state_q     <= END;
            quotient_q  <= q_neg_q ? -q_raw_d : q_raw_d;
            remainder_q <= r_neg_q ? -r_raw_d : r_raw_d;
            ready_q     <= 1'b1;
          end else begin
            pr_q  <= pr_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        END: begin
          // Hold the result until EX drops start, then clear for the next op.
          if (!start) begin
            state_q     <= FREE;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ready     = ready_q;
  assign stop_req  = start & ~annul & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Purpose : scoreboard bench for div_seq: directed division vectors, annul, reset, divide-by-zero.
// Latency : expected results queued at issue time, popped by a monitor on each ready rising.
// Backpr. : stimulus holds start until ready (or drops it early on one vector) as EX would.
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         annul;
  logic         signed_div;
  logic [W-1:0] opdata1;
  logic [W-1:0] opdata2;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         ready;
  logic         stop_req;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .annul     (annul),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (ready),
    .stop_req  (stop_req)
  );

  int             vectors     = 0;
  int             miscompares = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_e;
  logic           ready_prev  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new result is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected_ready: got q=%h r=%h, expected no result", quotient, remainder);
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_quotient", 64'(quotient), 64'(exp_e[2*W-1:W]));
        check("sb_remainder", 64'(remainder), 64'(exp_e[W-1:0]));
      end
    end
    ready_prev = ready;
  end

  // One complete request: issue, wait for ready, check latency/stall/hold, release.
  task automatic do_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit early_drop);
    int n;
    bit stall_ok;
    int lat_exp;
    lat_exp = (b == '0) ? 2 : W + 2;  // edges counted from the acceptance edge, inclusive
    exp_q.push_back({eq, er});
    @(posedge clk); #1;
    start = 1'b1; signed_div = sd; opdata1 = a; opdata2 = b;
    @(negedge clk);
    check("stop_req_accept", 64'(stop_req), 64'd1);
    n = 0;
    stall_ok = 1'b1;
    do begin
      @(posedge clk);
      n++;
      if (early_drop && n == 3) begin
        #1 start = 1'b0;
      end
      @(negedge clk);
      if (!ready && !stop_req && !early_drop) stall_ok = 1'b0;
    end while (!ready && n < 200);
    check("ready_latency", 64'(n), 64'(lat_exp));
    if (!early_drop) check("stall_held", 64'(stall_ok), 64'd1);
    check("stop_req_with_ready", 64'(stop_req), 64'd0);
    if (!early_drop) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("end_hold", {31'd0, ready, quotient}, {31'd0, 1'b1, eq});
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("cleared", {31'd0, ready, quotient | remainder}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_stop", {62'd0, ready, stop_req}, 64'd0);
    check("reset_q_r", {quotient, remainder}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors: signed flag, dividend, divisor, quotient, remainder, early start drop
    do_div(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    do_div(1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0000,  1'b0);
    do_div(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  32'h8000_0000,  1'b0);
    do_div(1'b1, 32'd1234,       32'd0,          32'd0,          32'd0,          1'b0);
    do_div(1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0000_0001,  1'b0);
    do_div(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0);
    do_div(1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
    do_div(1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b1);
    do_div(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);

    // start and annul together in FREE: no acceptance, no stall
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    @(negedge clk);
    check("stop_req_annul_free", 64'(stop_req), 64'd0);
    repeat (3) @(posedge clk);
    #1 start = 1'b0; annul = 1'b0;
    repeat (40) @(negedge clk);
    check("no_accept_with_annul", 64'(ready), 64'd0);

    // annul mid-operation
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    check("stop_req_annul", 64'(stop_req), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    check("annul_free", {31'd0, ready, quotient | remainder}, 64'd0);
    repeat (40) @(negedge clk);
    check("annul_no_ready", 64'(ready), 64'd0);
    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // reset mid-operation
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_ready_stop", {62'd0, ready, stop_req}, 64'd0);
    check("reset_mid_q_r", {quotient, remainder}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("reset_no_ready", 64'(ready), 64'd0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
